// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: a 16-entry sign-magnitude Q9.14 register file plus a
// small command FSM that feeds an external ALU, waits for it, and writes back.
module alu_op_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [3:0]  cmd_ra,
   input  logic [3:0]  cmd_rb,
   input  logic [3:0]  cmd_rd,
   input  logic        ld_en,
   input  logic [3:0]  ld_addr,
   input  logic [23:0] ld_data,
   input  logic [3:0]  rd_addr,
   output logic [23:0] rd_data,
   output logic [23:0] alu_R,
   output logic [23:0] alu_S,
   output logic        alu_ctl_f,
   output logic        alu_ctl_e,
   output logic        alu_rst,
   input  logic [23:0] alu_result,
   input  logic        alu_cont,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WB
   } state_t;

   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_INV = 2'b11;

   state_t      state;
   logic [1:0]  op_q;
   logic [3:0]  rd_q;
   logic [4:0]  wait_cnt;
   logic [23:0] regs [16];
   logic [23:0] ra_val;
   logic [23:0] rb_val;

   assign ra_val    = regs[cmd_ra];
   assign rb_val    = regs[cmd_rb];
   assign rd_data   = regs[rd_addr];
   assign cmd_ready = (state == S_IDLE);
   assign busy      = ~cmd_ready;

   // Register file: external loads first, write-back last so it wins on an address clash
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (ld_en) begin
            regs[ld_addr] <= ld_data;
         end
         if (state == S_WB) begin
            regs[rd_q] <= alu_result;
         end
      end
   end

   // Command FSM: latches operands on acceptance and drives the ALU until write-back or timeout
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         op_q      <= '0;
         rd_q      <= '0;
         wait_cnt  <= '0;
         alu_R     <= '0;
         alu_S     <= '0;
         alu_ctl_f <= 1'b0;
         alu_ctl_e <= 1'b0;
         alu_rst   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done    <= 1'b0;
         alu_rst <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  rd_q      <= cmd_rd;
                  alu_R     <= ra_val;
                  alu_S     <= (cmd_op == OP_SUB) ? {~rb_val[23], rb_val[22:0]} : rb_val;
                  alu_ctl_f <= cmd_op[1];
                  alu_ctl_e <= (cmd_op == OP_INV);
                  alu_rst   <= (cmd_op == OP_INV);
                  err       <= 1'b0;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wait_cnt <= '0;
               state    <= (op_q == OP_INV) ? S_WAIT : S_WB;
            end
            S_WAIT: begin
               if (alu_cont) begin
                  state <= S_WB;
               end else if (wait_cnt == 5'd31) begin
                  err       <= 1'b1;
                  done      <= 1'b1;
                  alu_R     <= '0;
                  alu_S     <= '0;
                  alu_ctl_f <= 1'b0;
                  alu_ctl_e <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 5'd1;
               end
            end
            S_WB: begin
               done      <= 1'b1;
               alu_R     <= '0;
               alu_S     <= '0;
               alu_ctl_f <= 1'b0;
               alu_ctl_e <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU responder, reference register
// model and a done-driven scoreboard.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_ra, cmd_rb, cmd_rd;
   logic        ld_en;
   logic [3:0]  ld_addr;
   logic [23:0] ld_data;
   logic [3:0]  rd_addr;
   logic [23:0] rd_data;
   logic [23:0] alu_R, alu_S;
   logic        alu_ctl_f, alu_ctl_e, alu_rst;
   logic [23:0] alu_result;
   logic        alu_cont;
   logic        busy, done, err;

   logic [3:0]  stimAddr;
   logic [3:0]  monAddr;
   logic        monReq;

   int checks   = 0;
   int failures = 0;

   logic [23:0] mreg [16];

   typedef struct {
      logic [3:0]  rd;
      logic [23:0] val;
      logic        err;
   } exp_t;

   exp_t sbq [$];

   alu_op_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .alu_R(alu_R), .alu_S(alu_S), .alu_ctl_f(alu_ctl_f), .alu_ctl_e(alu_ctl_e),
      .alu_rst(alu_rst), .alu_result(alu_result), .alu_cont(alu_cont),
      .busy(busy), .done(done), .err(err)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Sign-magnitude Q9.14 arithmetic: add, multiply, reciprocal
   function automatic logic [23:0] aluModel(input logic f, input logic e,
                                            input logic [23:0] r, input logic [23:0] s);
      longint ma, mb, sa, sb, v;
      logic   sg;
      ma = longint'(r[22:0]);
      mb = longint'(s[22:0]);
      if (!f) begin
         sa = r[23] ? -ma : ma;
         sb = s[23] ? -mb : mb;
         v  = sa + sb;
         sg = (v < 0);
         if (v < 0) v = -v;
         return {sg, v[22:0]};
      end else if (!e) begin
         v = (ma * mb) >>> 14;
         return {r[23] ^ s[23], v[22:0]};
      end else begin
         if (ma == 0) return {r[23], 23'h7FFFFF};
         v = (longint'(1) <<< 28) / ma;
         return {r[23], v[22:0]};
      end
   endfunction

   // The ALU responds combinationally to whatever operands the DUT presents
   always_comb alu_result = aluModel(alu_ctl_f, alu_ctl_e, alu_R, alu_S);

   // Register-file read port is shared between the stimulus and the monitor
   always_comb rd_addr = monReq ? monAddr : stimAddr;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expected completion
   initial begin
      exp_t e;
      monReq  = 1'b0;
      monAddr = '0;
      forever begin
         @(negedge clk);
         if (rst && done) begin
            if (sbq.size() == 0) begin
               checkOutput("unexpected_done", done, 0);
            end else begin
               e = sbq.pop_front();
               checkOutput("err_on_done", err, e.err);
               monAddr = e.rd;
               monReq  = 1'b1;
               #1;
               checkOutput("rd_after_done", rd_data, e.val);
               monReq  = 1'b0;
            end
         end
      end
   end

   task automatic doLoad(input logic [3:0] a, input logic [23:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      step();
      ld_en     = 1'b0;
      mreg[a]   = d;
      stimAddr  = a;
      #1;
      checkOutput("load_readback", rd_data, d);
   endtask

   task automatic checkRegEquals(input string name, input logic [3:0] a, input logic [23:0] d);
      stimAddr = a;
      #1;
      checkOutput(name, rd_data, d);
   endtask

   task automatic resetPulse();
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 16; i++) mreg[i] = '0;
   endtask

   // Issue one command; optional register load at cycle ldCycle after acceptance
   // (-1 = none) and for INV the ALU completes contDelay cycles after acceptance
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] rd, input int contDelay, input int ldCycle,
                                input logic [3:0] ldA, input logic [23:0] ldD);
      logic [23:0] a, b, sExp, res, finalV;
      logic        fExp, eExp, timeout, ldHit;
      int          expLat, pos, guard;
      bit          seen;
      exp_t        e;
      a    = mreg[ra];
      b    = mreg[rb];
      fExp = op[1];
      eExp = (op == 2'b11);
      sExp = (op == 2'b01) ? {~b[23], b[22:0]} : b;
      res  = aluModel(fExp, eExp, a, sExp);
      timeout = (op == 2'b11) && (contDelay > 32);
      expLat  = (op != 2'b11) ? 2 : (timeout ? 33 : contDelay + 2);
      ldHit   = (ldCycle >= 0) && (ldCycle < expLat) && (ldA == rd);
      finalV  = timeout ? (ldHit ? ldD : mreg[rd]) : res;

      guard = 0;
      while (!cmd_ready && guard < 50) begin
         step();
         guard++;
      end
      if (!cmd_ready) begin
         checkOutput("ready_wait", cmd_ready, 1);
         return;
      end
      alu_cont  = (op == 2'b11) ? 1'b0 : 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_ra    = ra;
      cmd_rb    = rb;
      cmd_rd    = rd;
      e.rd  = rd;
      e.val = finalV;
      e.err = timeout;
      sbq.push_back(e);
      step();
      cmd_valid = 1'b0;

      checkOutput("issue_alu_R", alu_R, a);
      if (op != 2'b11) checkOutput("issue_alu_S", alu_S, sExp);
      checkOutput("issue_ctl_f", alu_ctl_f, fExp);
      checkOutput("issue_ctl_e", alu_ctl_e, eExp);
      checkOutput("issue_alu_rst", alu_rst, eExp);
      checkOutput("issue_ready_low", cmd_ready, 0);
      checkOutput("issue_err_cleared", err, 0);

      pos  = 0;
      seen = 0;
      while (!seen && pos < 40) begin
         checkOutput("busy_while_active", busy, 1);
         if (pos == 1) checkOutput("alu_rst_one_cycle", alu_rst, 0);
         ld_en   = (ldCycle == pos);
         ld_addr = ldA;
         ld_data = ldD;
         if (ldCycle == pos) mreg[ldA] = ldD;
         if (op == 2'b11 && pos == contDelay) alu_cont = 1'b1;
         step();
         pos++;
         ld_en = 1'b0;
         if (done) seen = 1;
      end
      checkOutput("done_latency", seen ? pos : -1, expLat);
      alu_cont = 1'b1;
      if (!timeout) mreg[rd] = res;

      checkOutput("idle_alu_R", alu_R, 0);
      checkOutput("idle_alu_S", alu_S, 0);
      checkOutput("idle_ctl", {alu_ctl_f, alu_ctl_e}, 0);
      checkOutput("idle_ready", cmd_ready, 1);
      checkOutput("idle_err", err, timeout);
   endtask

   // Global watchdog
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      logic [23:0] r1, r2;
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0; stimAddr = '0; alu_cont = 1'b1;
      for (int i = 0; i < 16; i++) mreg[i] = '0;
      step();
      step();
      rst = 1'b1;

      checkOutput("reset_ready", cmd_ready, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_alu_rst", alu_rst, 0);
      checkOutput("reset_alu_R", alu_R, 0);
      for (int i = 0; i < 16; i++) checkRegEquals("reset_reg", 4'(i), 24'h0);

      // SUB 1.5 - 0.5
      doLoad(4'd1, 24'h006000);
      doLoad(4'd2, 24'h002000);
      applyStimulus(2'b01, 4'd1, 4'd2, 4'd3, 0, -1, 4'd0, 24'h0);
      step();
      checkRegEquals("sub_result_r3", 4'd3, 24'h004000);

      // MUL with cmd_valid held: the follow-on ADD waits for done
      r1 = mreg[1];
      begin
         exp_t e;
         e.rd = 4'd4; e.val = aluModel(1'b1, 1'b0, r1, r1); e.err = 1'b0;
         sbq.push_back(e);
         cmd_valid = 1'b1; cmd_op = 2'b10; cmd_ra = 4'd1; cmd_rb = 4'd1; cmd_rd = 4'd4;
         step();
         cmd_op = 2'b00; cmd_ra = 4'd4; cmd_rb = 4'd4; cmd_rd = 4'd7;
         checkOutput("b2b_ctl_f", alu_ctl_f, 1);
         checkOutput("b2b_ctl_e", alu_ctl_e, 0);
         checkOutput("b2b_ready_issue", cmd_ready, 0);
         step();
         checkOutput("b2b_ready_wb", cmd_ready, 0);
         checkOutput("b2b_done_wb", done, 0);
         step();
         checkOutput("b2b_done", done, 1);
         checkOutput("b2b_ready_done", cmd_ready, 1);
         mreg[4] = e.val;
         checkRegEquals("mul_result_r4", 4'd4, 24'h009000);
         r2 = mreg[4];
         e.rd = 4'd7; e.val = aluModel(1'b0, 1'b0, r2, r2); e.err = 1'b0;
         sbq.push_back(e);
         step();
         cmd_valid = 1'b0;
         checkOutput("b2b_second_R", alu_R, r2);
         checkOutput("b2b_second_busy", busy, 1);
         step();
         step();
         checkOutput("b2b_second_done", done, 1);
         mreg[7] = e.val;
      end

      // INV completing after 24 cycles, at the last legal cycle, then timing out
      applyStimulus(2'b11, 4'd1, 4'd0, 4'd5, 24, -1, 4'd0, 24'h0);
      applyStimulus(2'b11, 4'd2, 4'd0, 4'd6, 32, -1, 4'd0, 24'h0);
      applyStimulus(2'b11, 4'd1, 4'd0, 4'd3, 40, -1, 4'd0, 24'h0);
      step(); step(); step();
      checkOutput("err_sticky", err, 1);

      // Write-back beats a same-cycle load to rd; a load elsewhere still lands
      applyStimulus(2'b00, 4'd1, 4'd2, 4'd3, 0, 1, 4'd3, 24'h123456);
      step();
      checkRegEquals("collision_r3", 4'd3, 24'h008000);
      applyStimulus(2'b00, 4'd1, 4'd2, 4'd3, 0, 1, 4'd9, 24'h00ABCD);
      // Load to a source register after acceptance leaves the operand alone
      applyStimulus(2'b10, 4'd2, 4'd1, 4'd8, 0, 0, 4'd2, 24'h7FFFFF);

      // Randomised command mix
      for (int n = 0; n < 40; n++) begin
         int          nl, cd, lc;
         logic [1:0]  op;
         nl = $urandom_range(0, 2);
         for (int k = 0; k < nl; k++) doLoad(4'($urandom_range(0, 15)), 24'($urandom));
         op = 2'($urandom_range(0, 3));
         cd = (op == 2'b11) ? $urandom_range(1, 36) : 0;
         lc = $urandom_range(0, 3) - 1;
         applyStimulus(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), cd, lc, 4'($urandom_range(0, 15)), 24'($urandom));
      end

      // Reset in the middle of an INV wait aborts it cleanly
      for (int k = 0; k < 4; k++) doLoad(4'($urandom_range(0, 15)), 24'($urandom) | 24'h000100);
      alu_cont = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_ra = 4'd1; cmd_rb = 4'd2; cmd_rd = 4'd10;
      step();
      cmd_valid = 1'b0;
      checkOutput("abort_alu_rst", alu_rst, 1);
      for (int k = 0; k < 5; k++) step();
      checkOutput("abort_busy_wait", busy, 1);
      resetPulse();
      checkOutput("abort_ready", cmd_ready, 1);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_err", err, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_ctl_e", alu_ctl_e, 0);
      alu_cont = 1'b1;
      for (int k = 0; k < 4; k++) step();
      for (int i = 0; i < 16; i++) checkRegEquals("abort_reg_cleared", 4'(i), 24'h0);
      checkOutput("scoreboard_empty", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
